// File: rtl/conv_window_scheduler_if.sv
// rtl/conv_window_scheduler_if.sv - config, weight/pixel/output streams and multiplier-array bus of conv_window_scheduler
// master = scheduler side, slave = surrounding datapath and stream endpoints.
interface conv_window_scheduler_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5
);
  localparam int N = KERNEL_SIZE * KERNEL_SIZE;

  logic                    cfg_start;
  logic                    cfg_stop;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    w_valid;
  logic                    w_ready;
  logic [N*DATA_WIDTH-1:0] pix_window;
  logic                    pix_valid;
  logic                    pix_ready;
  logic [N*DATA_WIDTH-1:0] mult_weights;
  logic [N*DATA_WIDTH-1:0] mult_pixels;
  logic [N*DATA_WIDTH-1:0] mult_result;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic [15:0]             win_count;

  modport master (
    input  cfg_start, cfg_stop, w_data, w_valid, pix_window, pix_valid, mult_result, out_ready,
    output w_ready, pix_ready, mult_weights, mult_pixels, out_data, out_valid, busy, win_count
  );

  modport slave (
    output cfg_start, cfg_stop, w_data, w_valid, pix_window, pix_valid, mult_result, out_ready,
    input  w_ready, pix_ready, mult_weights, mult_pixels, out_data, out_valid, busy, win_count
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// rtl/conv_window_scheduler.sv - kernel loader plus two-stage window/sum pipeline for the KxK multiplier array
// Optional macro CONV_SAT_EN: saturate the lane sum to DATA_WIDTH instead of wrapping it.
module conv_window_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BIT    = 8,
  parameter int KERNEL_SIZE = 5
) (
  input logic                     clk,
  input logic                     rst_n,
  conv_window_scheduler_if.master bus
);
  localparam int N     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Products arrive already rescaled, so FRAC_BIT only needs to be sane.
  if (FRAC_BIT < 0 || FRAC_BIT >= DATA_WIDTH) begin : g_frac_check
    $error("conv_window_scheduler: FRAC_BIT must lie in [0, DATA_WIDTH)");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   weights_q [N];
  logic [N*DATA_WIDTH-1:0] pix_q;
  logic                    s1_valid_q, s1_valid_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [15:0]             win_count_q, win_count_d;
  logic [DATA_WIDTH-1:0]   narrow_c;
  logic                    w_ready_c, pix_ready_c, busy_c;
  logic                    adv, pipe_empty, w_fire, pix_fire, s2_fire, last_word;

  assign adv        = !out_valid_q || bus.out_ready;
  assign pipe_empty = !s1_valid_q && !out_valid_q;
  assign w_fire     = bus.w_valid && w_ready_c;
  assign pix_fire   = bus.pix_valid && pix_ready_c;
  assign s2_fire    = s1_valid_q && adv;
  assign last_word  = w_fire && (idx_q == IDX_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Reload wins over stop; both wait for the pipe to drain so the bank never moves under a window.
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.cfg_start) state_d = ST_LOAD;
      ST_LOAD: if (last_word) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.cfg_start) begin
          if (pipe_empty) state_d = ST_LOAD;
        end else if (bus.cfg_stop && pipe_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : outputs
    w_ready_c   = 1'b0;
    pix_ready_c = 1'b0;
    busy_c      = (state_q != ST_IDLE) || !pipe_empty;
    case (state_q)
      ST_LOAD: w_ready_c = 1'b1;
      ST_RUN:  pix_ready_c = !bus.cfg_start && !bus.cfg_stop && (adv || !s1_valid_q);
      default: ;
    endcase
  end

`ifdef CONV_SAT_EN
  localparam int SUM_W = DATA_WIDTH + $clog2(N);
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [SUM_W-1:0] sum_c;

  always_comb begin : lane_sum
    sum_c = '0;
    for (int i = 0; i < N; i++)
      sum_c = sum_c + SUM_W'($signed(bus.mult_result[i*DATA_WIDTH +: DATA_WIDTH]));
    if (sum_c > SAT_MAX)      narrow_c = SAT_MAX[DATA_WIDTH-1:0];
    else if (sum_c < SAT_MIN) narrow_c = SAT_MIN[DATA_WIDTH-1:0];
    else                      narrow_c = sum_c[DATA_WIDTH-1:0];
  end
`else
  // Wrapping result: the low DATA_WIDTH bits of the sign-extended sum equal a DATA_WIDTH-bit sum.
  always_comb begin : lane_sum
    narrow_c = '0;
    for (int i = 0; i < N; i++)
      narrow_c = narrow_c + bus.mult_result[i*DATA_WIDTH +: DATA_WIDTH];
  end
`endif

  always_comb begin : datapath_next
    idx_d = idx_q;
    if (state_q != ST_LOAD) idx_d = '0;
    else if (w_fire)        idx_d = last_word ? '0 : idx_q + IDX_W'(1);

    s1_valid_d  = pix_fire ? 1'b1 : (s2_fire ? 1'b0 : s1_valid_q);
    out_valid_d = s2_fire ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
    out_data_d  = s2_fire ? narrow_c : out_data_q;

    win_count_d = win_count_q;
    if (state_q == ST_IDLE || (state_q == ST_RUN && state_d == ST_LOAD))
      win_count_d = '0;
    else if (out_valid_q && bus.out_ready)
      win_count_d = win_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      win_count_q <= '0;
      pix_q       <= '0;
      for (int i = 0; i < N; i++) weights_q[i] <= '0;
    end else begin
      idx_q       <= idx_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      win_count_q <= win_count_d;
      if (pix_fire) pix_q <= bus.pix_window;
      if (w_fire)   weights_q[idx_q] <= bus.w_data;
    end
  end

  always_comb begin : weight_bus
    bus.mult_weights = '0;
    for (int i = 0; i < N; i++)
      bus.mult_weights[i*DATA_WIDTH +: DATA_WIDTH] = weights_q[i];
  end

  assign bus.mult_pixels = pix_q;
  assign bus.w_ready     = w_ready_c;
  assign bus.pix_ready   = pix_ready_c;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_c;
  assign bus.win_count   = win_count_q;
endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb/tb_conv_window_scheduler.sv - directed and randomized self-checking bench for conv_window_scheduler
module tb_conv_window_scheduler;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int KS = 5;
  localparam int N  = KS * KS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_scheduler_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS)) bus ();

  conv_window_scheduler #(.DATA_WIDTH(DW), .FRAC_BIT(FB), .KERNEL_SIZE(KS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Fixed-point multiplier array: product rescaled by FRAC_BIT, kept to DW bits.
  function automatic logic [DW-1:0] mul_lane(input logic [DW-1:0] w, input logic [DW-1:0] p);
    logic signed [2*DW-1:0] prod;
    prod = $signed(w) * $signed(p);
    return prod[FB +: DW];
  endfunction

  always_comb begin
    bus.mult_result = '0;
    for (int i = 0; i < N; i++)
      bus.mult_result[i*DW +: DW] = mul_lane(bus.mult_weights[i*DW +: DW], bus.mult_pixels[i*DW +: DW]);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer multiply, arithmetic rescale, 16-bit lane, integer sum, then wrap or clamp.
  function automatic logic [DW-1:0] ref_out(input logic [N*DW-1:0] k, input logic [N*DW-1:0] w);
    longint s;
    int kv, wv, prod;
    shortint lane;
    s = 0;
    for (int i = 0; i < N; i++) begin
      kv   = int'($signed(k[i*DW +: DW]));
      wv   = int'($signed(w[i*DW +: DW]));
      prod = kv * wv;
      lane = shortint'(prod >>> FB);
      s    = s + longint'(lane);
    end
`ifdef CONV_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[DW-1:0];
  endfunction

  function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] v);
    return {N{v}};
  endfunction

  function automatic logic [N*DW-1:0] rand_vec(input int span);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom_range(0, 2*span - 1) - span);
    return v;
  endfunction

  logic [N*DW-1:0] kern_m = '0;
  logic [DW-1:0]   exp_q[$];
  logic [DW-1:0]   out_log[$];
  int              accepts = 0;
  int              widx = 0;
  int              model_wc = 0;
  bit              hold_pending = 0;
  logic [DW-1:0]   hold_data;

  // One cycle: inputs already set at the falling edge; observe, update the model, advance.
  task automatic step();
    #1;
    if (hold_pending) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, hold_data);
    end
    hold_pending = 0;
    if (bus.out_valid && bus.out_ready) begin
      out_log.push_back(bus.out_data);
      check("out_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("out_data", bus.out_data, exp_q.pop_front());
      model_wc++;
    end else if (bus.out_valid) begin
      hold_pending = 1;
      hold_data    = bus.out_data;
    end
    if (bus.pix_valid && bus.pix_ready) begin
      exp_q.push_back(ref_out(kern_m, bus.pix_window));
      accepts++;
    end
    if (bus.w_valid && bus.w_ready) begin
      kern_m[widx*DW +: DW] = bus.w_data;
      widx++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_kernel(input logic [N*DW-1:0] k, input bit gaps, input int nwords);
    int guard;
    guard = 0;
    bus.cfg_start = 1'b1;
    while (!bus.w_ready && guard < 50) begin
      step();
      guard++;
    end
    check("load_enter", guard < 50, 1);
    bus.cfg_start = 1'b0;
    widx     = 0;
    model_wc = 0;
    check("wc_clear", bus.win_count, 0);
    guard = 0;
    while (widx < nwords && guard < 400) begin
      bus.w_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.w_data  = k[widx*DW +: DW];
      step();
      guard++;
    end
    bus.w_valid = 1'b0;
    check("load_words", guard < 400, 1);
    if (nwords == N) begin
      check("mult_weights", bus.mult_weights, k);
      check("run_w_ready", bus.w_ready, 0);
    end
  endtask

  task automatic send_one(input logic [N*DW-1:0] win, input logic [DW-1:0] exp_const, input string tag);
    int a0;
    a0 = accepts;
    bus.out_ready  = 1'b1;
    bus.pix_valid  = 1'b1;
    bus.pix_window = win;
    step();
    check({tag, "_accept"}, accepts - a0, 1);
    check({tag, "_pixels"}, bus.mult_pixels, win);
    bus.pix_valid = 1'b0;
    #1 check({tag, "_lat1"}, bus.out_valid, 0);
    step();
    #1 check({tag, "_lat2"}, bus.out_valid, 1);
    check(tag, bus.out_data, exp_const);
    step();
  endtask

  task automatic drain(input int limit);
    int guard;
    guard = 0;
    while ((exp_q.size() > 0 || bus.out_valid) && guard < limit) begin
      bus.out_ready = 1'b1;
      step();
      guard++;
    end
    check("drain", guard < limit, 1);
  endtask

  initial begin
    int a0, guard, target;

    bus.cfg_start = 0; bus.cfg_stop = 0; bus.w_data = '0; bus.w_valid = 0;
    bus.pix_window = '0; bus.pix_valid = 0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_w_ready", bus.w_ready, 0);
    check("rst_pix_ready", bus.pix_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_win_count", bus.win_count, 0);
    check("rst_weights", bus.mult_weights, 0);
    check("rst_pixels", bus.mult_pixels, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    load_kernel(fill(16'h0100), 1'b0, N);
    send_one(fill(16'h0100), 16'h1900, "unit");
    check("unit_wc", bus.win_count, 1);
    send_one(fill(16'hFF00), 16'hE700, "negative");
`ifdef CONV_SAT_EN
    send_one(fill(16'h7F00), 16'h7FFF, "overflow");
`else
    send_one(fill(16'h7F00), 16'h6700, "overflow");
`endif

    out_log.delete();
    a0 = accepts;
    for (int c = 0; c < 5; c++) begin
      bus.out_ready  = 1'b0;
      bus.pix_valid  = (accepts - a0) < 4;
      bus.pix_window = fill(DW'((accepts - a0 + 1) * 256));
      step();
    end
    check("bp_accepts", accepts - a0, 2);
    guard = 0;
    while (((accepts - a0) < 4 || exp_q.size() > 0 || bus.out_valid) && guard < 100) begin
      bus.out_ready  = 1'b1;
      bus.pix_valid  = (accepts - a0) < 4;
      bus.pix_window = fill(DW'((accepts - a0 + 1) * 256));
      step();
      guard++;
    end
    bus.pix_valid = 1'b0;
    check("bp_done", guard < 100, 1);
    check("bp_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      check("bp_out0", out_log[0], 16'h1900);
      check("bp_out1", out_log[1], 16'h3200);
      check("bp_out2", out_log[2], 16'h4B00);
      check("bp_out3", out_log[3], 16'h6400);
    end

    out_log.delete();
    bus.out_ready  = 1'b1;
    bus.pix_valid  = 1'b1;
    bus.pix_window = fill(16'h0100);
    step();
    step();
    bus.pix_valid = 1'b0;
    load_kernel(fill(16'h0200), 1'b1, N);
    check("reload_drained", out_log.size(), 2);
    if (out_log.size() == 2) begin
      check("reload_old0", out_log[0], 16'h1900);
      check("reload_old1", out_log[1], 16'h1900);
    end
    send_one(fill(16'h0100), 16'h3200, "reload_new");

    bus.cfg_stop = 1'b1;
    step();
    bus.cfg_stop = 1'b0;
    check("stop_busy", bus.busy, 0);
    check("stop_pix_ready", bus.pix_ready, 0);

    load_kernel(rand_vec(2048), 1'b1, N);
    target = accepts + 60;
    guard  = 0;
    while ((accepts < target || exp_q.size() > 0 || bus.out_valid) && guard < 3000) begin
      bus.pix_valid  = (accepts < target) && ($urandom_range(0, 9) < 7);
      bus.pix_window = rand_vec(($urandom_range(0, 1) != 0) ? 32768 : 1024);
      bus.out_ready  = $urandom_range(0, 9) < 6;
      step();
      guard++;
    end
    bus.pix_valid = 1'b0;
    check("rand_done", guard < 3000, 1);
    check("rand_wc", bus.win_count, DW'(model_wc));
    drain(20);

    load_kernel(fill(16'h0300), 1'b0, 10);
    #2 rst_n = 1'b0;
    #1;
    check("arst_w_ready", bus.w_ready, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_weights", bus.mult_weights, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_win_count", bus.win_count, 0);
    exp_q.delete();
    kern_m = '0;
    widx = 0;
    hold_pending = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_kernel(fill(16'h0100), 1'b0, N);
    send_one(fill(16'h0100), 16'h1900, "after_rst");
    check("after_rst_wc", bus.win_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
